// File: rtl/flee_capture_pkg.sv
// Shared types and constants for the flee0/flee1 capture endpoint.
//   cap_state_t  : capture FSM state
//   cnt_t        : default-width packet count (AW+1 bits for the default DEPTH)
//   lfsr_next()  : one step of the 16-bit stall LFSR
package flee_capture_pkg;

  localparam int unsigned DEPTH_DEF   = 1024;
  localparam int unsigned AW_DEF      = 10;
  localparam int unsigned TIMEOUT_DEF = 5000;
  localparam logic [15:0] LFSR_SD_DEF = 16'hACE1;

  // Fibonacci taps 16,14,13,11 -> bits 15,13,12,10 of a left-shifting register.
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    DONE    = 2'd2
  } cap_state_t;

  typedef logic [AW_DEF:0] cnt_t;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[14:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/flee_capture_lane.sv
// One capture lane: in-order RAM, saturating packet count, sticky overflow and a
// registered read port.
//   clk, rstn       : clock, async active-low reset
//   clear           : restart pulse, clears count and overflow
//   capture         : FSM is in CAPTURE
//   stall           : pseudo-random backpressure for this lane
//   valid/data/ready: packet handshake
//   rd_en, rd_addr  : readback request, rd_data valid one cycle later
//   cnt, overflow   : status
module flee_capture_lane #(
  parameter int unsigned DW    = 32,
  parameter int unsigned DEPTH = 1024,
  parameter int unsigned AW    = 10
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          clear,
  input  logic          capture,
  input  logic          stall,
  input  logic          valid,
  input  logic [DW-1:0] data,
  output logic          ready,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data,
  output logic [AW:0]   cnt,
  output logic          overflow
);

  logic [DW-1:0] mem [DEPTH];
  logic [AW:0]   cnt_q;
  logic          ovf_q;
  logic [DW-1:0] rd_q;
  logic          full;
  logic          we;

  assign full  = (cnt_q == (AW + 1)'(DEPTH));
  // Ready comes from registered state only, never from valid.
  assign ready = capture & ~full & ~stall;
  // A restart discards anything offered in the same cycle.
  assign we    = valid & ready & ~clear;

  always_ff @(posedge clk) begin
    if (we) mem[cnt_q[AW-1:0]] <= data;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q <= '0;
      ovf_q <= 1'b0;
      rd_q  <= '0;
    end else begin
      if (clear) begin
        cnt_q <= '0;
        ovf_q <= 1'b0;
      end else begin
        if (we) cnt_q <= cnt_q + 1'b1;
        if (capture & valid & full) ovf_q <= 1'b1;
      end
      // Same-cycle write is not visible: the read sees the old word.
      if (rd_en) rd_q <= mem[rd_addr];
    end
  end

  assign cnt      = cnt_q;
  assign overflow = ovf_q;
  assign rd_data  = rd_q;

endmodule

// File: rtl/flee_capture.sv
// Receive-side endpoint for the two NoC egress ports flee0/flee1.
// Captures both streams into per-lane RAMs, counts packets, signals done on
// expected counts or on link idle timeout, and offers a synchronous readback.
//   clk, rstn                  : clock, async active-low reset
//   start                      : clear lanes and (re)enter CAPTURE
//   exp_cnt0/1                 : expected packet counts
//   stall_en                   : enable LFSR backpressure
//   floeN_data/valid/ready     : lane N handshake (N = 0,1)
//   cnt0/1, done, timed_out,
//   overflow                   : status
//   rd_en/rd_lane/rd_addr      : readback request; rd_data/rd_valid one cycle later
module flee_capture
  import flee_capture_pkg::*;
#(
  parameter int unsigned DW      = 32,
  parameter int unsigned DEPTH   = DEPTH_DEF,
  parameter int unsigned AW      = AW_DEF,
  parameter int unsigned TIMEOUT = TIMEOUT_DEF,
  parameter logic [15:0] LFSR_SD = LFSR_SD_DEF
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          start,
  input  logic [AW:0]   exp_cnt0,
  input  logic [AW:0]   exp_cnt1,
  input  logic          stall_en,
  input  logic [DW-1:0] flee0_data,
  input  logic          flee0_valid,
  output logic          flee0_ready,
  input  logic [DW-1:0] flee1_data,
  input  logic          flee1_valid,
  output logic          flee1_ready,
  output logic [AW:0]   cnt0,
  output logic [AW:0]   cnt1,
  output logic          done,
  output logic          timed_out,
  output logic [1:0]    overflow,
  input  logic          rd_en,
  input  logic          rd_lane,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data,
  output logic          rd_valid
);

  localparam int unsigned IW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  cap_state_t    state_q;
  logic [IW-1:0] idle_q;
  logic [15:0]   lfsr_q;
  logic          done_q;
  logic          timed_out_q;
  logic          rd_valid_q;
  logic          rd_lane_q;
  logic [DW-1:0] rd_data0;
  logic [DW-1:0] rd_data1;

  logic capture;
  logic hs_any;
  logic complete;
  logic idle_max;

  assign capture  = (state_q == CAPTURE);
  assign hs_any   = (flee0_valid & flee0_ready) | (flee1_valid & flee1_ready);
  assign complete = (cnt0 >= exp_cnt0) && (cnt1 >= exp_cnt1);
  assign idle_max = (idle_q == IW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      idle_q      <= '0;
      lfsr_q      <= LFSR_SD;
      done_q      <= 1'b0;
      timed_out_q <= 1'b0;
      rd_valid_q  <= 1'b0;
      rd_lane_q   <= 1'b0;
    end else begin
      lfsr_q     <= lfsr_next(lfsr_q);
      rd_valid_q <= rd_en;
      if (rd_en) rd_lane_q <= rd_lane;

      if (start) begin
        state_q     <= CAPTURE;
        idle_q      <= '0;
        done_q      <= 1'b0;
        timed_out_q <= 1'b0;
      end else if (state_q == CAPTURE) begin
        if (hs_any)         idle_q <= '0;
        else if (!idle_max) idle_q <= idle_q + 1'b1;
        // Completion has priority over the timeout exit.
        if (complete) begin
          state_q <= DONE;
          done_q  <= 1'b1;
        end else if (idle_max && (|{cnt0, cnt1})) begin
          state_q     <= DONE;
          done_q      <= 1'b1;
          timed_out_q <= 1'b1;
        end
      end
    end
  end

  flee_capture_lane #(
    .DW   (DW),
    .DEPTH(DEPTH),
    .AW   (AW)
  ) u_lane0 (
    .clk     (clk),
    .rstn    (rstn),
    .clear   (start),
    .capture (capture),
    .stall   (lfsr_q[0] & stall_en),
    .valid   (flee0_valid),
    .data    (flee0_data),
    .ready   (flee0_ready),
    .rd_en   (rd_en & ~rd_lane),
    .rd_addr (rd_addr),
    .rd_data (rd_data0),
    .cnt     (cnt0),
    .overflow(overflow[0])
  );

  flee_capture_lane #(
    .DW   (DW),
    .DEPTH(DEPTH),
    .AW   (AW)
  ) u_lane1 (
    .clk     (clk),
    .rstn    (rstn),
    .clear   (start),
    .capture (capture),
    .stall   (lfsr_q[1] & stall_en),
    .valid   (flee1_valid),
    .data    (flee1_data),
    .ready   (flee1_ready),
    .rd_en   (rd_en & rd_lane),
    .rd_addr (rd_addr),
    .rd_data (rd_data1),
    .cnt     (cnt1),
    .overflow(overflow[1])
  );

  assign rd_data   = rd_lane_q ? rd_data1 : rd_data0;
  assign rd_valid  = rd_valid_q;
  assign done      = done_q;
  assign timed_out = timed_out_q;

endmodule

// File: tb/tb_flee_capture.sv
module tb_flee_capture;

  localparam int unsigned DW      = 32;
  localparam int unsigned DEPTH   = 1024;
  localparam int unsigned AW      = 10;
  localparam int unsigned TIMEOUT = 5000;

  logic          clk;
  logic          rstn;
  logic          start;
  logic [AW:0]   exp_cnt0, exp_cnt1;
  logic          stall_en;
  logic [DW-1:0] flee0_data, flee1_data;
  logic          flee0_valid, flee1_valid;
  logic          flee0_ready, flee1_ready;
  logic [AW:0]   cnt0, cnt1;
  logic          done, timed_out;
  logic [1:0]    overflow;
  logic          rd_en, rd_lane;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic          rd_valid;

  flee_capture #(
    .DW     (DW),
    .DEPTH  (DEPTH),
    .AW     (AW),
    .TIMEOUT(TIMEOUT),
    .LFSR_SD(16'hACE1)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .start      (start),
    .exp_cnt0   (exp_cnt0),
    .exp_cnt1   (exp_cnt1),
    .stall_en   (stall_en),
    .flee0_data (flee0_data),
    .flee0_valid(flee0_valid),
    .flee0_ready(flee0_ready),
    .flee1_data (flee1_data),
    .flee1_valid(flee1_valid),
    .flee1_ready(flee1_ready),
    .cnt0       (cnt0),
    .cnt1       (cnt1),
    .done       (done),
    .timed_out  (timed_out),
    .overflow   (overflow),
    .rd_en      (rd_en),
    .rd_lane    (rd_lane),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  // Packets offered (tx) and packets the sender saw accepted, in order (rx).
  logic [DW-1:0] tx0[$], tx1[$], rx0[$], rx1[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
    rx0.delete();
    rx1.delete();
  endtask

  // Offer tx0[0..n0-1] / tx1[0..n1-1]; valid optionally gapped at random.
  task automatic stream(input int n0, input int n1, input bit rnd, input int budget,
                        output int a0, output int a1, output bit saw_stall);
    int  cyc = 0;
    bit  hs0, hs1;
    a0 = 0;
    a1 = 0;
    saw_stall = 1'b0;
    while ((a0 < n0 || a1 < n1) && cyc < budget) begin
      flee0_valid = (a0 < n0) && (!rnd || ($urandom() & 1) == 1);
      flee1_valid = (a1 < n1) && (!rnd || ($urandom() & 1) == 1);
      flee0_data  = (a0 < n0) ? tx0[a0] : '0;
      flee1_data  = (a1 < n1) ? tx1[a1] : '0;
      @(negedge clk);
      hs0 = flee0_valid & flee0_ready;
      hs1 = flee1_valid & flee1_ready;
      if ((flee0_valid && !flee0_ready) || (flee1_valid && !flee1_ready)) saw_stall = 1'b1;
      step();
      if (hs0) begin rx0.push_back(tx0[a0]); a0++; end
      if (hs1) begin rx1.push_back(tx1[a1]); a1++; end
      cyc++;
    end
    flee0_valid = 1'b0;
    flee1_valid = 1'b0;
  endtask

  task automatic readback(input bit lane, input int n);
    for (int i = 0; i < n; i++) begin
      rd_en   = 1'b1;
      rd_lane = lane;
      rd_addr = AW'(i);
      step();
      rd_en = 1'b0;
      chk("rd_valid", rd_valid, 1'b1);
      chk(lane ? "rd_lane1" : "rd_lane0", rd_data, lane ? rx1[i] : rx0[i]);
    end
  endtask

  int a0, a1;
  bit stl;

  initial begin
    rstn = 1'b0; start = 1'b0; exp_cnt0 = '0; exp_cnt1 = '0; stall_en = 1'b0;
    flee0_data = '0; flee1_data = '0; flee0_valid = 1'b0; flee1_valid = 1'b0;
    rd_en = 1'b0; rd_lane = 1'b0; rd_addr = '0;
    repeat (3) step();
    chk("rst_cnt0", cnt0, 0);
    chk("rst_cnt1", cnt1, 0);
    chk("rst_done", done, 0);
    chk("rst_timed_out", timed_out, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_ready0", flee0_ready, 0);
    chk("rst_ready1", flee1_ready, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_rd_data", rd_data, 0);
    rstn = 1'b1;
    step();
    chk("idle_ready0", flee0_ready, 0);

    // 1: reset mid-stream
    exp_cnt0 = 100; exp_cnt1 = 100;
    do_start();
    tx0.delete();
    for (int i = 0; i < 7; i++) tx0.push_back($urandom());
    stream(7, 0, 1'b0, 50, a0, a1, stl);
    flee0_valid = 1'b1;
    #1;
    chk("t1_cnt0", cnt0, 7);
    chk("t1_ready_pre", flee0_ready, 1);
    rstn = 1'b0;
    #1;
    chk("t1_ready_async0", flee0_ready, 0);
    chk("t1_ready_async1", flee1_ready, 0);
    flee0_valid = 1'b0;
    step();
    rstn = 1'b1;
    step();
    chk("t1_cnt0_after", cnt0, 0);
    chk("t1_done_after", done, 0);
    chk("t1_idle_ready", flee0_ready, 0);

    // 2: basic capture
    exp_cnt0 = 4; exp_cnt1 = 3; stall_en = 1'b0;
    tx0 = '{32'hA0, 32'hA1, 32'hA2, 32'hA3};
    tx1 = '{32'hB0, 32'hB1, 32'hB2};
    do_start();
    stream(4, 3, 1'b0, 50, a0, a1, stl);
    chk("t2_acc0", a0, 4);
    chk("t2_acc1", a1, 3);
    chk("t2_no_stall", stl, 0);
    chk("t2_done_early", done, 0);
    step();
    chk("t2_done", done, 1);
    chk("t2_cnt0", cnt0, 4);
    chk("t2_cnt1", cnt1, 3);
    chk("t2_timed_out", timed_out, 0);
    chk("t2_ready_done", flee0_ready, 0);
    rd_en = 1'b1; rd_lane = 1'b0; rd_addr = 2;
    step();
    rd_en = 1'b0;
    chk("t2_rd_valid", rd_valid, 1);
    chk("t2_rd_a2", rd_data, 32'hA2);
    step();
    chk("t2_rd_valid_drop", rd_valid, 0);
    readback(1'b1, 3);

    // 3: simultaneous lanes, lock-step counts
    exp_cnt0 = 8; exp_cnt1 = 8;
    do_start();
    for (int i = 0; i < 8; i++) begin
      flee0_valid = 1'b1; flee1_valid = 1'b1;
      flee0_data = $urandom(); flee1_data = $urandom();
      step();
      rx0.push_back(flee0_data);
      rx1.push_back(flee1_data);
      chk("t3_cnt0", cnt0, i + 1);
      chk("t3_cnt1", cnt1, i + 1);
    end
    flee0_valid = 1'b0; flee1_valid = 1'b0;
    step();
    chk("t3_done", done, 1);
    readback(1'b0, 8);
    readback(1'b1, 8);

    // 4: backpressure, 992 packets on lane 0
    exp_cnt0 = 992; exp_cnt1 = 0; stall_en = 1'b1;
    tx0.delete();
    for (int i = 0; i < 992; i++) tx0.push_back($urandom());
    do_start();
    stream(992, 0, 1'b1, 20000, a0, a1, stl);
    chk("t4_acc0", a0, 992);
    chk("t4_stalled", stl, 1);
    chk("t4_cnt0", cnt0, 992);
    step();
    chk("t4_done", done, 1);
    chk("t4_rx_len", rx0.size(), 992);
    for (int i = 0; i < 992 && i < rx0.size(); i++)
      if (rx0[i] !== tx0[i]) chk("t4_order", rx0[i], tx0[i]);
    readback(1'b0, rx0.size());
    stall_en = 1'b0;

    // 5: overflow
    exp_cnt0 = DEPTH + 1; exp_cnt1 = 0;
    tx0.delete();
    for (int i = 0; i < DEPTH + 2; i++) tx0.push_back($urandom());
    do_start();
    stream(DEPTH + 2, 0, 1'b0, DEPTH + 8, a0, a1, stl);
    chk("t5_acc0", a0, DEPTH);
    chk("t5_cnt0", cnt0, DEPTH);
    chk("t5_ready0", flee0_ready, 0);
    chk("t5_overflow", overflow, 2'b01);
    chk("t5_done", done, 0);
    rd_en = 1'b1; rd_lane = 1'b0; rd_addr = AW'(DEPTH - 1);
    step();
    rd_en = 1'b0;
    chk("t5_last", rd_data, tx0[DEPTH-1]);

    // 6: timeout
    exp_cnt0 = 0; exp_cnt1 = 10;
    tx1.delete();
    for (int i = 0; i < 5; i++) tx1.push_back($urandom());
    do_start();
    chk("t6_ovf_clr", overflow, 0);
    stream(0, 5, 1'b0, 50, a0, a1, stl);
    chk("t6_acc1", a1, 5);
    repeat (TIMEOUT - 1) step();
    chk("t6_done_early", done, 0);
    step();
    chk("t6_done", done, 1);
    chk("t6_timed_out", timed_out, 1);
    chk("t6_cnt1", cnt1, 5);
    do_start();
    chk("t6_done_clr", done, 0);
    chk("t6_to_clr", timed_out, 0);
    chk("t6_cnt1_clr", cnt1, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
